// File: rtl/mm_fact_subsystem_if.sv
// Data-bus bundle for mm_fact_subsystem: CPU-side bus, interrupt-controller
// pass-through and per-unit completion flags.
interface mm_fact_subsystem_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        data_valid;
  logic        intc_we;
  logic [31:0] intc_addr;
  logic [31:0] intc_wdata;
  logic [31:0] intc_rdata;
  logic [3:0]  fact_done;

  modport master (
    output we, addr, wdata, intc_rdata,
    input  rdata, data_valid, intc_we, intc_addr, intc_wdata, fact_done
  );

  modport slave (
    input  we, addr, wdata, intc_rdata,
    output rdata, data_valid, intc_we, intc_addr, intc_wdata, fact_done
  );
endinterface

// File: rtl/mm_fact_subsystem.sv
// Memory-mapped subsystem: addr[11:8] decoder, 64-word data memory,
// interrupt-controller pass-through and four factorial accelerators.
module mm_fact_subsystem (
  input  logic               clk,
  input  logic               rst,
  mm_fact_subsystem_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fact_state_t;

  logic [3:0]  sel_s;
  logic [1:0]  reg_s;
  logic [5:0]  widx_s;
  logic        dmem_we_s;
  logic [31:0] rdata_s;
  logic [31:0] fact_rdata_s [4];
  logic [3:0]  fact_done_s;
  logic        unused_ok;

  logic [31:0] mem_q [64];

  assign sel_s     = bus.addr[11:8];
  assign reg_s     = bus.addr[3:2];
  assign widx_s    = bus.addr[7:2];
  assign dmem_we_s = bus.we && (sel_s == 4'h0);
  assign unused_ok = ^{bus.addr[31:12], bus.addr[1:0]};

  // Data memory: synchronous write, no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (dmem_we_s) begin
      mem_q[widx_s] <= bus.wdata;
    end
  end

  assign bus.intc_we    = bus.we && (sel_s == 4'h1);
  assign bus.intc_addr  = bus.addr;
  assign bus.intc_wdata = bus.wdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fact
    fact_state_t state_q;
    logic [3:0]  n_q;
    logic [3:0]  nlat_q;
    logic [3:0]  cnt_q;
    logic        go_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] prod_q;
    logic [31:0] result_q;
    logic [31:0] mul_s;
    logic [31:0] rd_s;
    logic        unit_we_s;
    logic        start_s;

    assign unit_we_s = bus.we && (sel_s == 4'(gi + 2));
    assign start_s   = unit_we_s && (reg_s == 2'd1) && bus.wdata[0] && (state_q != S_BUSY);
    assign mul_s     = prod_q * {28'd0, cnt_q};

    // Register file and IDLE/BUSY/DONE sequencer; N is latched at start so
    // later N writes cannot disturb a running computation.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= S_IDLE;
        n_q      <= 4'd0;
        nlat_q   <= 4'd0;
        cnt_q    <= 4'd0;
        go_q     <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        prod_q   <= 32'd0;
        result_q <= 32'd0;
      end else begin
        if (unit_we_s && (reg_s == 2'd0)) begin
          n_q <= bus.wdata[3:0];
        end
        if (unit_we_s && (reg_s == 2'd1)) begin
          go_q <= bus.wdata[0];
        end
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_s) begin
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              cnt_q   <= n_q;
              nlat_q  <= n_q;
              prod_q  <= 32'd1;
              state_q <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (nlat_q > 4'd12) begin
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              result_q <= 32'd0;
              state_q  <= S_DONE;
            end else if (cnt_q > 4'd1) begin
              prod_q <= mul_s;
              cnt_q  <= cnt_q - 4'd1;
            end else begin
              result_q <= prod_q;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    // Unit register read mux.
    always_comb begin
      case (reg_s)
        2'd0:    rd_s = {28'd0, n_q};
        2'd1:    rd_s = {31'd0, go_q};
        2'd2:    rd_s = {30'd0, err_q, done_q};
        2'd3:    rd_s = result_q;
        default: rd_s = 32'd0;
      endcase
    end

    assign fact_rdata_s[gi] = rd_s;
    assign fact_done_s[gi]  = done_q;
  end

  // Bus read mux; unmapped selectors read as zero.
  always_comb begin
    case (sel_s)
      4'h0:    rdata_s = mem_q[widx_s];
      4'h1:    rdata_s = bus.intc_rdata;
      4'h2:    rdata_s = fact_rdata_s[0];
      4'h3:    rdata_s = fact_rdata_s[1];
      4'h4:    rdata_s = fact_rdata_s[2];
      4'h5:    rdata_s = fact_rdata_s[3];
      default: rdata_s = 32'd0;
    endcase
  end

  assign bus.rdata      = rdata_s;
  assign bus.data_valid = (sel_s <= 4'h5);
  assign bus.fact_done  = fact_done_s;

endmodule

// File: tb/tb_mm_fact_subsystem.sv
// Directed self-checking bench for mm_fact_subsystem.
module tb_mm_fact_subsystem;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  mm_fact_subsystem_if bus_if ();

  mm_fact_subsystem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    #1;
    chk(tag, bus_if.rdata, exp);
  endtask

  initial begin
    n_chk             = 0;
    n_pass            = 0;
    rst               = 1'b1;
    bus_if.we         = 1'b0;
    bus_if.addr       = 32'd0;
    bus_if.wdata      = 32'd0;
    bus_if.intc_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_fact_done", {28'd0, bus_if.fact_done}, 32'd0);
    read_chk("rst_f0_n", 32'h200, 32'd0);
    read_chk("rst_f0_status", 32'h208, 32'd0);
    read_chk("rst_f3_result", 32'h50C, 32'd0);

    // 1. Data memory
    bus_write(32'h004, 32'hDEADBEEF);
    bus_write(32'h0FC, 32'h12345678);
    read_chk("dmem_04", 32'h004, 32'hDEADBEEF);
    chk("dmem_valid", {31'd0, bus_if.data_valid}, 32'd1);
    read_chk("dmem_fc", 32'h0FC, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    read_chk("dmem_after_rst", 32'h004, 32'hDEADBEEF);

    // Read during same-address write shows old data until the edge
    bus_write(32'h008, 32'h11111111);
    @(negedge clk);
    bus_if.we    = 1'b1;
    bus_if.addr  = 32'h008;
    bus_if.wdata = 32'h22222222;
    #1;
    chk("rw_same_old", bus_if.rdata, 32'h11111111);
    @(posedge clk);
    #1;
    chk("rw_same_new", bus_if.rdata, 32'h22222222);
    bus_if.we = 1'b0;

    // 2. fact0 N=5
    bus_write(32'h200, 32'd5);
    read_chk("f0_n_rb", 32'h200, 32'd5);
    bus_write(32'h204, 32'd1);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      #1;
      read_chk($sformatf("f0_status_e%0d", j), 32'h208, (j == 5) ? 32'd1 : 32'd0);
    end
    chk("f0_fact_done", {28'd0, bus_if.fact_done}, 32'h1);
    read_chk("f0_result", 32'h20C, 32'd120);
    read_chk("f0_go_rb", 32'h204, 32'd1);

    // 3. fact3 N=12, N=0, N=13
    bus_write(32'h500, 32'd12);
    bus_write(32'h504, 32'd1);
    repeat (11) @(posedge clk);
    #1;
    read_chk("f3_n12_status_e11", 32'h508, 32'd0);
    @(posedge clk);
    #1;
    read_chk("f3_n12_status_e12", 32'h508, 32'd1);
    read_chk("f3_n12_result", 32'h50C, 32'd479001600);

    bus_write(32'h500, 32'd0);
    bus_write(32'h504, 32'd1);
    @(posedge clk);
    #1;
    read_chk("f3_n0_status", 32'h508, 32'd1);
    read_chk("f3_n0_result", 32'h50C, 32'd1);

    bus_write(32'h500, 32'd13);
    bus_write(32'h504, 32'd1);
    @(posedge clk);
    #1;
    read_chk("f3_n13_status", 32'h508, 32'd3);
    read_chk("f3_n13_result", 32'h50C, 32'd0);
    chk("f3_fact_done", {28'd0, bus_if.fact_done}, 32'h9);

    // 4. Concurrency and GO while busy
    bus_write(32'h300, 32'd6);
    bus_write(32'h400, 32'd4);
    bus_write(32'h304, 32'd1);
    bus_write(32'h404, 32'd1);
    bus_write(32'h304, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("conc_e4", {30'd0, bus_if.fact_done[2:1]}, 32'd0);
    @(posedge clk);
    #1;
    chk("conc_e5", {30'd0, bus_if.fact_done[2:1]}, 32'd2);
    @(posedge clk);
    #1;
    chk("conc_e6", {30'd0, bus_if.fact_done[2:1]}, 32'd3);
    read_chk("f1_result", 32'h30C, 32'd720);
    read_chk("f2_result", 32'h40C, 32'd24);

    // 5. Decode boundaries and intc pass-through
    read_chk("unmap_600", 32'h600, 32'd0);
    chk("unmap_600_valid", {31'd0, bus_if.data_valid}, 32'd0);
    read_chk("unmap_f00", 32'hF00, 32'd0);
    chk("unmap_f00_valid", {31'd0, bus_if.data_valid}, 32'd0);
    bus_write(32'h604, 32'hFFFFFFFF);
    bus_write(32'hF0C, 32'hFFFFFFFF);
    read_chk("unmap_wr_dmem", 32'h004, 32'hDEADBEEF);
    read_chk("unmap_wr_f0", 32'h20C, 32'd120);
    @(negedge clk);
    bus_if.intc_rdata = 32'hA5A5A5A5;
    bus_if.addr       = 32'hFFFF_F1F0;
    bus_if.wdata      = 32'h5A5A0001;
    bus_if.we         = 1'b1;
    #1;
    chk("intc_we_hi", {31'd0, bus_if.intc_we}, 32'd1);
    chk("intc_rdata", bus_if.rdata, 32'hA5A5A5A5);
    chk("intc_valid", {31'd0, bus_if.data_valid}, 32'd1);
    chk("intc_addr", bus_if.intc_addr, 32'hFFFF_F1F0);
    chk("intc_wdata", bus_if.intc_wdata, 32'h5A5A0001);
    bus_if.we = 1'b0;
    #1;
    chk("intc_we_lo", {31'd0, bus_if.intc_we}, 32'd0);
    bus_if.addr = 32'h000;
    bus_if.we   = 1'b1;
    #1;
    chk("intc_we_other", {31'd0, bus_if.intc_we}, 32'd0);
    bus_if.we = 1'b0;

    // 6. Reset mid-operation
    bus_write(32'h200, 32'd10);
    bus_write(32'h204, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_fact_done", {28'd0, bus_if.fact_done}, 32'd0);
    read_chk("rstmid_status", 32'h208, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_write(32'h200, 32'd10);
    bus_write(32'h204, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    read_chk("reissue_status_e9", 32'h208, 32'd0);
    @(posedge clk);
    #1;
    read_chk("reissue_status_e10", 32'h208, 32'd1);
    read_chk("reissue_result", 32'h20C, 32'd3628800);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
